// File: rtl/memory_system.sv
// Memory and I/O subsystem behind the CPU: 128 B ROM, 96 B RAM, 16 output and 16 synchronized input ports,
// plus a byte-stream program loader that holds the CPU in reset while it fills the array.
module memory_system #(
    parameter int PROG_BYTES  = 224,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   address,
    input  logic [7:0]   data_in,
    input  logic         write_en,
    output logic [7:0]   data_out,
    input  logic [127:0] port_in,
    output logic [127:0] port_out,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic [7:0]   load_data,
    output logic         load_ready,
    output logic         load_done,
    output logic         cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_PTR = 8'(PROG_BYTES - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_ptr;
    logic [7:0]     w_ptr_next;
    logic           w_xfer;
    logic           w_hold_next;
    logic           w_cpu_we;
    logic [7:0]     w_rdata;
    logic [7:0]     r_data_out;
    logic [127:0]   r_port_out;
    logic [127:0]   r_sync [SYNC_STAGES];
    logic [127:0]   w_sync;
    logic [7:0]     r_mem [0:223];

    // Loader FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_xfer       = 1'b0;
        load_ready   = 1'b0;
        load_done    = 1'b0;
        cpu_hold     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_next = S_LOAD;
                    w_ptr_next   = '0;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (load_valid) begin
                    w_xfer     = 1'b1;
                    w_ptr_next = r_ptr + 8'd1;
                    if (r_ptr == LAST_PTR) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                load_done    = 1'b1;
                cpu_hold     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_hold_next = (w_state_next != S_IDLE);
    assign w_cpu_we    = write_en && !cpu_hold;

    // Array has no reset; the loader owns it while cpu_hold is high, so the two writers never collide.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_ptr] <= load_data;
        end else if (w_cpu_we && address >= 8'h80 && address < 8'hE0) begin
            r_mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port_out <= '0;
        end else if (w_cpu_we && address[7:4] == 4'hE) begin
            r_port_out[{address[3:0], 3'b000} +: 8] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= port_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_rdata = '0;
        if (address < 8'hE0) begin
            w_rdata = r_mem[address];
        end else if (!address[4]) begin
            w_rdata = r_port_out[{address[3:0], 3'b000} +: 8];
        end else begin
            w_rdata = w_sync[{address[3:0], 3'b000} +: 8];
        end
    end

    // Forcing on the next hold value keeps data_out at zero for every cycle cpu_hold is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_hold_next) begin
            r_data_out <= '0;
        end else begin
            r_data_out <= w_rdata;
        end
    end

    assign data_out = r_data_out;
    assign port_out = r_port_out;

endmodule

// File: tb/tb_memory_system.sv
// Directed self-checking bench for memory_system (PROG_BYTES=4, SYNC_STAGES=2).
module tb_memory_system;

    logic         clk;
    logic         rst;
    logic [7:0]   address;
    logic [7:0]   data_in;
    logic         write_en;
    logic [7:0]   data_out;
    logic [127:0] port_in;
    logic [127:0] port_out;
    logic         load_start;
    logic         load_valid;
    logic [7:0]   load_data;
    logic         load_ready;
    logic         load_done;
    logic         cpu_hold;

    int n_run  = 0;
    int n_fail = 0;

    memory_system #(.PROG_BYTES(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .data_in    (data_in),
        .write_en   (write_en),
        .data_out   (data_out),
        .port_in    (port_in),
        .port_out   (port_out),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        address    = 8'h00;
        data_in    = 8'h00;
        write_en   = 1'b0;
        port_in    = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        step();
        step();
        chk("rst_data_out", 128'(data_out), 128'h0);
        chk("rst_port_out", port_out, 128'h0);
        chk("rst_ready", 128'(load_ready), 128'h0);
        chk("rst_done", 128'(load_done), 128'h0);
        chk("rst_hold", 128'(cpu_hold), 128'h0);
        rst = 1'b1;
        step();

        // Full load of 4 bytes with load_valid held high
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h86;
        step();
        load_start = 1'b0;
        chk("ld1_hold", 128'(cpu_hold), 128'h1);
        chk("ld1_ready", 128'(load_ready), 128'h1);
        chk("ld1_dout", 128'(data_out), 128'h0);
        step();
        load_data = 8'h80;
        chk("ld1_b0_ready", 128'(load_ready), 128'h1);
        step();
        load_data = 8'h96;
        chk("ld1_b1_done", 128'(load_done), 128'h0);
        step();
        load_data = 8'hE0;
        chk("ld1_b2_ready", 128'(load_ready), 128'h1);
        step();
        load_valid = 1'b0;
        chk("ld1_b3_ready", 128'(load_ready), 128'h0);
        chk("ld1_b3_done", 128'(load_done), 128'h1);
        chk("ld1_b3_hold", 128'(cpu_hold), 128'h1);
        chk("ld1_b3_dout", 128'(data_out), 128'h0);
        step();
        chk("ld1_idle_done", 128'(load_done), 128'h0);
        chk("ld1_idle_hold", 128'(cpu_hold), 128'h0);

        address = 8'h00; step(); chk("rom0", 128'(data_out), 128'h86);
        address = 8'h01; step(); chk("rom1", 128'(data_out), 128'h80);
        address = 8'h02; step(); chk("rom2", 128'(data_out), 128'h96);
        address = 8'h03; step(); chk("rom3", 128'(data_out), 128'hE0);

        // RAM write/read and read-before-write
        address = 8'h90; data_in = 8'h5A; write_en = 1'b1;
        step();
        write_en = 1'b0;
        step();
        chk("ram_5a", 128'(data_out), 128'h5A);
        data_in = 8'h11; write_en = 1'b1;
        step();
        write_en = 1'b0;
        chk("ram_rbw_old", 128'(data_out), 128'h5A);
        step();
        chk("ram_rbw_new", 128'(data_out), 128'h11);

        // ROM write ignored
        address = 8'h02; data_in = 8'h77; write_en = 1'b1;
        step();
        write_en = 1'b0;
        step();
        chk("rom_wr_ign", 128'(data_out), 128'h96);

        // Output port write
        address = 8'hE2; data_in = 8'hC3; write_en = 1'b1;
        step();
        write_en = 1'b0;
        chk("port_e2", port_out, 128'hC3 << 16);
        step();
        chk("port_e2_rd", 128'(data_out), 128'hC3);

        // Input port synchronizer latency
        address = 8'hFF;
        step();
        port_in[127:120] = 8'hA5;
        step(); chk("sync_e1", 128'(data_out), 128'h0);
        step(); chk("sync_e2", 128'(data_out), 128'h0);
        step(); chk("sync_e3", 128'(data_out), 128'hA5);
        address = 8'hF5; data_in = 8'h33; write_en = 1'b1;
        step();
        write_en = 1'b0;
        step();
        chk("inport_wr_ign", 128'(data_out), 128'h0);
        chk("inport_wr_port_out", port_out, 128'hC3 << 16);

        // Asynchronous reset clears ports immediately
        rst = 1'b0;
        #1;
        chk("arst_port_out", port_out, 128'h0);
        chk("arst_dout", 128'(data_out), 128'h0);
        rst = 1'b1;
        step();

        // Load with wait states and blocked CPU writes, then abort by reset
        address = 8'hE0; data_in = 8'h3C; write_en = 1'b1;
        step();
        write_en = 1'b0;
        chk("pre_port_e0", port_out, 128'h3C);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        data_in = 8'hFF; write_en = 1'b1;
        load_valid = 1'b1; load_data = 8'h11;
        step();
        chk("ws_v1_dout", 128'(data_out), 128'h0);
        load_valid = 1'b0;
        step();
        chk("ws_v0a_port", port_out, 128'h3C);
        step();
        chk("ws_v0b_dout", 128'(data_out), 128'h0);
        load_valid = 1'b1; load_data = 8'h22;
        step();
        load_valid = 1'b0;
        chk("ws_v1b_dout", 128'(data_out), 128'h0);
        chk("ws_v1b_port", port_out, 128'h3C);
        chk("ws_v1b_hold", 128'(cpu_hold), 128'h1);
        chk("ws_v1b_done", 128'(load_done), 128'h0);

        rst = 1'b0;
        #1;
        chk("abort_hold", 128'(cpu_hold), 128'h0);
        chk("abort_ready", 128'(load_ready), 128'h0);
        rst = 1'b1;
        write_en = 1'b0;
        address = 8'h00;
        step();
        chk("abort_no_done", 128'(load_done), 128'h0);
        chk("abort_rd0", 128'(data_out), 128'h11);
        address = 8'h01; step(); chk("abort_rd1", 128'(data_out), 128'h22);
        address = 8'h02; step(); chk("abort_rd2", 128'(data_out), 128'h96);

        // Restart from pointer 0
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 8'hAA; step();
        load_data = 8'hBB; step();
        load_data = 8'hCC; step();
        load_data = 8'hDD; step();
        load_valid = 1'b0;
        chk("rl_done", 128'(load_done), 128'h1);
        step();
        address = 8'h00; step(); chk("rl_rd0", 128'(data_out), 128'hAA);
        address = 8'h03; step(); chk("rl_rd3", 128'(data_out), 128'hDD);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
